memory_stage: RTL and testbench

Fourth stage of the five-stage pipeline. Consumes the EX/MEM results: ALU result, store data, return PC and flags. Owns the stack pointer and the 2K×16 data memory. Executes loads, stores, single-word PUSH/POP, and the multi-cycle 32-bit PC push/pop used by CALL/RET/INT/RTI. Produces the MEM/WB values and a stall that freezes the earlier stages during multi-word stack operations.

---
 rtl/memory_stage_pkg.sv | 27 ++
 rtl/memory_stage_data_mem.sv | 33 +++
 rtl/memory_stage.sv | 188 ++++++++++++++++++
 tb/tb_memory_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage and its neighbours.
//   DATA_W / ADDR_W : default data word width and data-memory address width
//   SP_RESET_VAL    : stack pointer value after reset
//   MEM_*           : bit positions inside the 6-bit MEM control bundle
//   mem_state_t     : multi-word stack sequencer states
package memory_stage_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 11;

    localparam logic [ADDR_W-1:0] SP_RESET_VAL = 11'h7FF;

    localparam int unsigned MEM_CTRL_W = 6;
    localparam int unsigned MEM_READ   = 0;
    localparam int unsigned MEM_WRITE  = 1;
    localparam int unsigned MEM_POP    = 2;
    localparam int unsigned MEM_PUSH   = 3;
    localparam int unsigned MEM_DOUBLE = 4;
    localparam int unsigned MEM_FLAGS  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WORD1 = 2'd1,
        WORD2 = 2'd2
    } mem_state_t;

endpackage

// File: rtl/memory_stage_data_mem.sv
// data_mem: 2^AW x W data memory.
//   clk   : write clock
//   we    : write enable (synchronous write at rising edge)
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : read data
// Contents are not reset.
module data_mem
    import memory_stage_pkg::*;
#(
    parameter int unsigned W  = DATA_W,
    parameter int unsigned AW = ADDR_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory_stage.sv
// memory_stage: fourth pipeline stage. Owns the stack pointer and data memory,
// performs loads/stores, single-word PUSH/POP and the multi-cycle PC push/pop
// sequences of CALL/RET (2 words) and INT/RTI (2 words + flags word).
//   clk, rst    : clock, asynchronous active-high reset
//   MEM         : {flags, double, push, pop, mem_write, mem_read}
//   ALU_Result  : load/store address, also forwarded as ALU_MW
//   Store_Data  : data for STD / PUSH
//   PC_In       : return PC pushed by CALL/INT
//   Flags_In    : flags pushed by INT
//   ALU_MW      : registered ALU_Result (holds while Stall)
//   Mem_Data    : registered load / single pop data
//   PC_Pop      : registered popped PC
//   Flags_Pop   : registered popped flags
//   PC_Valid    : one-cycle pulse after the final word of a PC pop
//   SP_Low      : zero-extended stack pointer
//   Stall       : combinational hold request to earlier stages
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned   W        = DATA_W,
    parameter int unsigned   AW       = ADDR_W,
    parameter logic [AW-1:0] SP_RESET = SP_RESET_VAL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MEM_CTRL_W-1:0] MEM,
    input  logic [W-1:0]          ALU_Result,
    input  logic [W-1:0]          Store_Data,
    input  logic [31:0]           PC_In,
    input  logic [2:0]            Flags_In,
    output logic [W-1:0]          ALU_MW,
    output logic [W-1:0]          Mem_Data,
    output logic [31:0]           PC_Pop,
    output logic [2:0]            Flags_Pop,
    output logic                  PC_Valid,
    output logic [W-1:0]          SP_Low,
    output logic                  Stall
);

    mem_state_t    state, state_next;
    logic [AW-1:0] sp, sp_next, sp_inc, sp_dec;

    logic          we;
    logic [AW-1:0] waddr, raddr;
    logic [W-1:0]  wdata, rdata;

    logic load_data, load_lo, load_hi, load_flags, final_pop;

    logic rd, wr, dbl, flg, stack, push_op, pop_op;

    assign rd      = MEM[MEM_READ];
    assign wr      = MEM[MEM_WRITE];
    assign dbl     = MEM[MEM_DOUBLE];
    assign flg     = MEM[MEM_FLAGS];
    // push together with pop cancels out: no SP change, no write
    assign stack   = MEM[MEM_PUSH] | MEM[MEM_POP];
    assign push_op = MEM[MEM_PUSH] & ~MEM[MEM_POP];
    assign pop_op  = MEM[MEM_POP]  & ~MEM[MEM_PUSH];

    assign sp_inc = sp + 1'b1;
    assign sp_dec = sp - 1'b1;

    assign Stall  = ((state == IDLE) & dbl) | ((state == WORD1) & flg);
    assign SP_Low = W'(sp);

    data_mem #(
        .W  (W),
        .AW (AW)
    ) u_data_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Word order: push goes PC high, PC low, flags (descending addresses);
    // pop mirrors it, so RTI takes flags first and RET/RTI end on PC high.
    always_comb begin
        state_next = state;
        sp_next    = sp;
        we         = 1'b0;
        waddr      = ALU_Result[AW-1:0];
        wdata      = Store_Data;
        raddr      = ALU_Result[AW-1:0];
        load_data  = 1'b0;
        load_lo    = 1'b0;
        load_hi    = 1'b0;
        load_flags = 1'b0;
        final_pop  = 1'b0;

        case (state)
            IDLE: begin
                if (dbl) begin
                    state_next = WORD1;
                    if (push_op) begin
                        we      = 1'b1;
                        waddr   = sp;
                        wdata   = W'(PC_In[31:16]);
                        sp_next = sp_dec;
                    end else if (pop_op) begin
                        raddr      = sp_inc;
                        sp_next    = sp_inc;
                        load_flags = flg;
                        load_lo    = ~flg;
                    end
                end else if (stack) begin
                    if (push_op) begin
                        we      = 1'b1;
                        waddr   = sp;
                        sp_next = sp_dec;
                    end else if (pop_op) begin
                        raddr     = sp_inc;
                        sp_next   = sp_inc;
                        load_data = 1'b1;
                    end
                end else begin
                    // read and write together: async read yields the pre-write word
                    we        = wr;
                    load_data = rd;
                end
            end
            WORD1: begin
                state_next = flg ? WORD2 : IDLE;
                if (dbl && push_op) begin
                    we      = 1'b1;
                    waddr   = sp;
                    wdata   = W'(PC_In[15:0]);
                    sp_next = sp_dec;
                end else if (dbl && pop_op) begin
                    raddr     = sp_inc;
                    sp_next   = sp_inc;
                    load_lo   = flg;
                    load_hi   = ~flg;
                    final_pop = ~flg;
                end
            end
            WORD2: begin
                state_next = IDLE;
                if (dbl && push_op) begin
                    we      = 1'b1;
                    waddr   = sp;
                    wdata   = W'(Flags_In);
                    sp_next = sp_dec;
                end else if (dbl && pop_op) begin
                    raddr     = sp_inc;
                    sp_next   = sp_inc;
                    load_hi   = 1'b1;
                    final_pop = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sp        <= SP_RESET;
            ALU_MW    <= '0;
            Mem_Data  <= '0;
            PC_Pop    <= '0;
            Flags_Pop <= '0;
            PC_Valid  <= 1'b0;
        end else begin
            state    <= state_next;
            sp       <= sp_next;
            PC_Valid <= final_pop;
            if (!Stall) begin
                ALU_MW <= ALU_Result;
            end
            if (load_data) begin
                Mem_Data <= rdata;
            end
            if (load_lo) begin
                PC_Pop[15:0] <= rdata[15:0];
            end
            if (load_hi) begin
                PC_Pop[31:16] <= rdata[15:0];
            end
            if (load_flags) begin
                Flags_Pop <= rdata[2:0];
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  MEM;
    logic [15:0] ALU_Result;
    logic [15:0] Store_Data;
    logic [31:0] PC_In;
    logic [2:0]  Flags_In;
    logic [15:0] ALU_MW;
    logic [15:0] Mem_Data;
    logic [31:0] PC_Pop;
    logic [2:0]  Flags_Pop;
    logic        PC_Valid;
    logic [15:0] SP_Low;
    logic        Stall;

    int unsigned n_cmp;
    int unsigned n_err;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_LDD  = 6'b000001;
    localparam logic [5:0] OP_STD  = 6'b000010;
    localparam logic [5:0] OP_RW   = 6'b000011;
    localparam logic [5:0] OP_POP  = 6'b000100;
    localparam logic [5:0] OP_PUSH = 6'b001000;
    localparam logic [5:0] OP_PP   = 6'b001100;
    localparam logic [5:0] OP_DBL  = 6'b010000;
    localparam logic [5:0] OP_CALL = 6'b011000;
    localparam logic [5:0] OP_RET  = 6'b010100;
    localparam logic [5:0] OP_INT  = 6'b111000;
    localparam logic [5:0] OP_RTI  = 6'b110100;

    memory_stage dut (
        .clk        (clk),
        .rst        (rst),
        .MEM        (MEM),
        .ALU_Result (ALU_Result),
        .Store_Data (Store_Data),
        .PC_In      (PC_In),
        .Flags_In   (Flags_In),
        .ALU_MW     (ALU_MW),
        .Mem_Data   (Mem_Data),
        .PC_Pop     (PC_Pop),
        .Flags_Pop  (Flags_Pop),
        .PC_Valid   (PC_Valid),
        .SP_Low     (SP_Low),
        .Stall      (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [5:0] m, input logic [15:0] alu, input logic [15:0] sd);
        MEM        = m;
        ALU_Result = alu;
        Store_Data = sd;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        set_op(OP_NOP, 16'h0000, 16'h0000);
        PC_In    = 32'h0;
        Flags_In = 3'b000;

        // reset state
        tick();
        chk("rst_sp", SP_Low, 32'h07FF);
        chk("rst_stall", Stall, 0);
        chk("rst_alu_mw", ALU_MW, 0);
        chk("rst_mem_data", Mem_Data, 0);
        chk("rst_pc_pop", PC_Pop, 0);
        chk("rst_flags_pop", Flags_Pop, 0);
        chk("rst_pc_valid", PC_Valid, 0);
        rst = 1'b0;

        // single push
        set_op(OP_PUSH, 16'h1111, 16'hABCD);
        tick();
        chk("push_sp", SP_Low, 32'h07FE);
        chk("push_alu_mw", ALU_MW, 32'h1111);

        // store with upper address bits set, plus a guard word at 0x7FE
        set_op(OP_STD, 16'hF805, 16'h1234);
        tick();
        set_op(OP_STD, 16'h07FE, 16'h0BAD);
        tick();
        chk("std_sp", SP_Low, 32'h07FE);

        set_op(OP_LDD, 16'h0005, 16'h0000);
        tick();
        chk("ldd_upper_ignored", Mem_Data, 32'h1234);
        set_op(OP_LDD, 16'h07FF, 16'h0000);
        tick();
        chk("ldd_pushed", Mem_Data, 32'hABCD);

        // read and write together
        set_op(OP_RW, 16'h0005, 16'h5555);
        tick();
        chk("rw_prewrite", Mem_Data, 32'h1234);
        set_op(OP_LDD, 16'h0005, 16'h0000);
        tick();
        chk("rw_written", Mem_Data, 32'h5555);

        // push and pop together: no SP change, no write
        set_op(OP_PP, 16'h0000, 16'h9999);
        tick();
        chk("pp_sp", SP_Low, 32'h07FE);
        set_op(OP_LDD, 16'h07FE, 16'h0000);
        tick();
        chk("pp_nowrite", Mem_Data, 32'h0BAD);

        // single pop
        set_op(OP_POP, 16'h3333, 16'h0000);
        tick();
        chk("pop_sp", SP_Low, 32'h07FF);
        chk("pop_data", Mem_Data, 32'hABCD);

        // CALL
        PC_In = 32'h0001_2345;
        set_op(OP_CALL, 16'h2222, 16'h0000);
        #1;
        chk("call_stall1", Stall, 1);
        tick();
        chk("call_stall2", Stall, 0);
        chk("call_alu_hold", ALU_MW, 32'h3333);
        chk("call_sp_mid", SP_Low, 32'h07FE);
        tick();
        chk("call_sp", SP_Low, 32'h07FD);
        chk("call_alu_mw", ALU_MW, 32'h2222);
        set_op(OP_LDD, 16'h07FF, 16'h0000);
        tick();
        chk("call_mem_hi", Mem_Data, 32'h0001);
        set_op(OP_LDD, 16'h07FE, 16'h0000);
        tick();
        chk("call_mem_lo", Mem_Data, 32'h2345);

        // RET
        set_op(OP_RET, 16'h0000, 16'h0000);
        #1;
        chk("ret_stall1", Stall, 1);
        tick();
        chk("ret_valid_mid", PC_Valid, 0);
        chk("ret_sp_mid", SP_Low, 32'h07FE);
        tick();
        chk("ret_valid", PC_Valid, 1);
        chk("ret_pc", PC_Pop, 32'h0001_2345);
        chk("ret_sp", SP_Low, 32'h07FF);
        set_op(OP_NOP, 16'h0000, 16'h0000);
        tick();
        chk("ret_valid_end", PC_Valid, 0);

        // INT
        PC_In    = 32'hBEEF_CAFE;
        Flags_In = 3'b101;
        set_op(OP_INT, 16'h0000, 16'h0000);
        #1;
        chk("int_stall1", Stall, 1);
        tick();
        chk("int_stall2", Stall, 1);
        tick();
        chk("int_stall3", Stall, 0);
        tick();
        chk("int_sp", SP_Low, 32'h07FC);

        // RTI
        set_op(OP_RTI, 16'h0000, 16'h0000);
        #1;
        chk("rti_stall1", Stall, 1);
        tick();
        chk("rti_stall2", Stall, 1);
        chk("rti_flags_first", Flags_Pop, 3'b101);
        tick();
        chk("rti_stall3", Stall, 0);
        chk("rti_valid_mid", PC_Valid, 0);
        tick();
        chk("rti_valid", PC_Valid, 1);
        chk("rti_pc", PC_Pop, 32'hBEEF_CAFE);
        chk("rti_flags", Flags_Pop, 3'b101);
        chk("rti_sp", SP_Low, 32'h07FF);
        set_op(OP_NOP, 16'h0000, 16'h0000);
        tick();
        chk("rti_valid_end", PC_Valid, 0);

        // SP wrap in both directions
        set_op(OP_STD, 16'h0000, 16'h7777);
        tick();
        set_op(OP_POP, 16'h0000, 16'h0000);
        tick();
        chk("wrap_pop_sp", SP_Low, 32'h0000);
        chk("wrap_pop_data", Mem_Data, 32'h7777);
        set_op(OP_PUSH, 16'h0000, 16'h4242);
        tick();
        chk("wrap_push_sp", SP_Low, 32'h07FF);
        set_op(OP_POP, 16'h0000, 16'h0000);
        tick();
        chk("wrap_pop2_sp", SP_Low, 32'h0000);
        chk("wrap_pop2_data", Mem_Data, 32'h4242);
        set_op(OP_POP, 16'h0000, 16'h0000);
        tick();
        chk("pre_int_sp", SP_Low, 32'h0001);

        // reset during WORD1 of an INT
        PC_In    = 32'h1357_2468;
        Flags_In = 3'b011;
        set_op(OP_INT, 16'h0000, 16'h0000);
        tick();
        chk("rint_sp_mid", SP_Low, 32'h0000);
        // with double-only MEM, Stall is high only if the FSM is back in IDLE
        set_op(OP_DBL, 16'h0000, 16'h0000);
        rst = 1'b1;
        #1;
        chk("rint_idle", Stall, 1);
        chk("rint_sp", SP_Low, 32'h07FF);
        chk("rint_valid", PC_Valid, 0);
        set_op(OP_NOP, 16'h0000, 16'h0000);
        tick();
        rst = 1'b0;
        set_op(OP_LDD, 16'h0001, 16'h0000);
        tick();
        chk("rint_partial_word", Mem_Data, 32'h1357);
        chk("rint_valid_after", PC_Valid, 0);
        chk("rint_sp_after", SP_Low, 32'h07FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
